// File: rtl/urna_pkg.sv
// Shared types and constants for the ballot-box results tally.
// Winner codes follow candidate numbering; code 0 means no candidate received votes.
package urna_pkg;

  localparam int NUM_CAND   = 4;
  localparam int BCD_DIGITS = 3;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    LOAD,
    CONV,
    DONE
  } state_t;

  localparam logic [2:0] WIN_NONE = 3'd0;
  localparam logic [2:0] WIN_C1   = 3'd1;
  localparam logic [2:0] WIN_C2   = 3'd2;
  localparam logic [2:0] WIN_C3   = 3'd3;
  localparam logic [2:0] WIN_C4   = 3'd4;

  function automatic logic [2:0] win_code(input logic [1:0] idx);
    logic [2:0] code;
    code = WIN_C1;
    case (idx)
      2'd0: code = WIN_C1;
      2'd1: code = WIN_C2;
      2'd2: code = WIN_C3;
      2'd3: code = WIN_C4;
      default: code = WIN_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per clock after a start pulse.
// Narrow inputs are left-aligned so the conversion always takes at least 8 shifts.
module bin2bcd_seq
  import urna_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] bin,
  output logic             done,
  output logic [11:0]      bcd
);

  localparam int SHIFTS = (CNT_W > 8) ? CNT_W : 8;
  localparam int BW     = 4 * BCD_DIGITS;
  localparam int SW     = BW + SHIFTS;

  logic [SW-1:0]     sr;
  logic [SW-1:0]     adj;
  logic [SHIFTS-1:0] aligned;
  logic [3:0]        bitcnt;
  logic              active;

  always_comb begin
    aligned = SHIFTS'(bin) << (SHIFTS - CNT_W);
    adj = sr;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (sr[SHIFTS + 4*d +: 4] >= 4'd5)
        adj[SHIFTS + 4*d +: 4] = sr[SHIFTS + 4*d +: 4] + 4'd3;
    end
    done = active && (bitcnt == 4'(SHIFTS - 1));
    // digits as they will stand after the shift pending this cycle
    bcd = BW'(adj >> (SHIFTS - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr     <= '0;
      bitcnt <= '0;
      active <= 1'b0;
    end else if (start) begin
      sr     <= {{BW{1'b0}}, aligned};
      bitcnt <= '0;
      active <= 1'b1;
    end else if (active) begin
      sr     <= adj << 1;
      bitcnt <= bitcnt + 4'd1;
      if (done) active <= 1'b0;
    end
  end

endmodule

// File: rtl/urna_apuracao.sv
// Election results tally: snapshots the vote counters on a Finish rise, finds winner/tie,
// sums the total and converts the winning count to BCD for the display stage.
//
// state | meaning
// IDLE  | waiting for a Finish rise
// SCAN  | comparing/summing candidates 1..4, one per cycle
// LOAD  | loading the winning count into the BCD converter
// CONV  | double-dabble shifting
// DONE  | results published; behaves as IDLE for the next rise
module urna_apuracao
  import urna_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Finish,
  input  logic [CNT_W-1:0] C1,
  input  logic [CNT_W-1:0] C2,
  input  logic [CNT_W-1:0] C3,
  input  logic [CNT_W-1:0] C4,
  input  logic [CNT_W-1:0] Nulo,
  output logic             Busy,
  output logic             Done,
  output logic [2:0]       Winner,
  output logic             Tie,
  output logic [11:0]      WinnerBCD,
  output logic [CNT_W+2:0] Total
);

  localparam int TW = CNT_W + 3;

  state_t           state, state_nxt;
  logic             finish_q;
  logic             rise;
  logic             start;
  logic [CNT_W-1:0] snap [NUM_CAND];
  logic [1:0]       idx;
  logic [2:0]       best;
  logic [CNT_W-1:0] bestval;
  logic             tie_r;
  logic [CNT_W-1:0] cur;
  logic             cvt_done;
  logic [11:0]      cvt_bcd;

  assign rise  = Finish && !finish_q;
  assign start = ((state == IDLE) || (state == DONE)) && rise;
  assign cur   = snap[idx];

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: state_nxt = rise ? SCAN : IDLE;
      SCAN:       if (idx == 2'(NUM_CAND - 1)) state_nxt = LOAD;
      LOAD:       state_nxt = CONV;
      CONV:       if (cvt_done) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      finish_q  <= 1'b0;
      for (int i = 0; i < NUM_CAND; i++) snap[i] <= '0;
      idx       <= '0;
      best      <= WIN_NONE;
      bestval   <= '0;
      tie_r     <= 1'b0;
      Total     <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Winner    <= WIN_NONE;
      Tie       <= 1'b0;
      WinnerBCD <= '0;
    end else begin
      finish_q <= Finish;
      if (start) begin
        snap[0] <= C1;
        snap[1] <= C2;
        snap[2] <= C3;
        snap[3] <= C4;
        idx     <= '0;
        best    <= WIN_NONE;
        bestval <= '0;
        tie_r   <= 1'b0;
        Total   <= TW'(Nulo);
        Done    <= 1'b0;
        Busy    <= 1'b1;
      end else if (state == SCAN) begin
        // strict > keeps the lowest index when counts are equal
        if (cur > bestval) begin
          best    <= win_code(idx);
          bestval <= cur;
          tie_r   <= 1'b0;
        end else if ((cur == bestval) && (bestval != '0)) begin
          tie_r <= 1'b1;
        end
        Total <= Total + TW'(cur);
        idx   <= idx + 2'd1;
      end else if ((state == CONV) && cvt_done) begin
        Winner    <= best;
        Tie       <= tie_r;
        WinnerBCD <= cvt_bcd;
        Busy      <= 1'b0;
        Done      <= 1'b1;
      end
    end
  end

  bin2bcd_seq #(.CNT_W(CNT_W)) u_bcd (
    .clk   (Clock),
    .rst   (Reset),
    .start (state == LOAD),
    .bin   (bestval),
    .done  (cvt_done),
    .bcd   (cvt_bcd)
  );

endmodule

// File: tb/tb_urna_apuracao.sv
// Scoreboard bench for urna_apuracao: stimulus queues expected results, a monitor checks them on Done.
module tb_urna_apuracao;

  localparam int CNT_W = 8;

  logic             Clock = 1'b0;
  logic             Reset = 1'b1;
  logic             Finish = 1'b0;
  logic [CNT_W-1:0] C1 = '0, C2 = '0, C3 = '0, C4 = '0, Nulo = '0;
  logic             Busy, Done, Tie;
  logic [2:0]       Winner;
  logic [11:0]      WinnerBCD;
  logic [CNT_W+2:0] Total;

  typedef struct {
    logic [2:0]  winner;
    logic        tie;
    logic [11:0] bcd;
    logic [10:0] total;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  logic done_prev = 1'b0;

  urna_apuracao #(.CNT_W(CNT_W)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Finish    (Finish),
    .C1        (C1),
    .C2        (C2),
    .C3        (C3),
    .C4        (C4),
    .Nulo      (Nulo),
    .Busy      (Busy),
    .Done      (Done),
    .Winner    (Winner),
    .Tie       (Tie),
    .WinnerBCD (WinnerBCD),
    .Total     (Total)
  );

  always #5 Clock = ~Clock;

  function automatic void check(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endfunction

  always @(negedge Clock) begin
    if (Done && !done_prev) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin
        mon_e = sb.pop_front();
        check("winner", int'(Winner), int'(mon_e.winner));
        check("tie", int'(Tie), int'(mon_e.tie));
        check("winner_bcd", int'(WinnerBCD), int'(mon_e.bcd));
        check("total", int'(Total), int'(mon_e.total));
      end
    end
    done_prev = Done;
  end

  // mode 0: plain run; 1: C2 cleared during SCAN; 2: Finish 1->0->1 while Busy
  task automatic run(input logic [7:0] c1, input logic [7:0] c2, input logic [7:0] c3,
                     input logic [7:0] c4, input logic [7:0] nulo,
                     input logic [2:0] w, input logic t, input logic [11:0] bcd,
                     input logic [10:0] tot, input int mode);
    exp_t x;
    int   k;
    bit   seen;
    C1 = c1; C2 = c2; C3 = c3; C4 = c4; Nulo = nulo;
    Finish = 1'b0;
    @(negedge Clock);
    Finish = 1'b1;
    x.winner = w; x.tie = t; x.bcd = bcd; x.total = tot;
    sb.push_back(x);
    k = 0;
    seen = 1'b0;
    while (!seen && k < 40) begin
      @(negedge Clock);
      k++;
      if (k == 1) begin
        check("busy_after_e0", int'(Busy), 1);
        check("done_cleared_at_start", int'(Done), 0);
      end
      if (k == 13) check("busy_after_e12", int'(Busy), 1);
      if (mode == 1 && k == 2) C2 = 8'd0;
      if (mode == 2 && k == 3) Finish = 1'b0;
      if (mode == 2 && k == 6) Finish = 1'b1;
      if (Done) seen = 1'b1;
    end
    check("done_latency_negedges", k, 14);
    check("busy_low_at_done", int'(Busy), 0);
    Finish = 1'b0;
    repeat (3) @(negedge Clock);
  endtask

  initial begin
    repeat (2) @(negedge Clock);
    check("rst_busy", int'(Busy), 0);
    check("rst_done", int'(Done), 0);
    check("rst_winner", int'(Winner), 0);
    check("rst_tie", int'(Tie), 0);
    check("rst_bcd", int'(WinnerBCD), 0);
    check("rst_total", int'(Total), 0);
    Reset = 1'b0;
    @(negedge Clock);

    run(8'd5,   8'd9,   8'd2,   8'd7,   8'd3,   3'd2, 1'b0, 12'h009, 11'd26,   0);
    run(8'd7,   8'd1,   8'd7,   8'd1,   8'd0,   3'd1, 1'b1, 12'h007, 11'd16,   0);
    run(8'd0,   8'd0,   8'd0,   8'd0,   8'd4,   3'd0, 1'b0, 12'h000, 11'd4,    0);
    run(8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 3'd1, 1'b1, 12'h255, 11'd1275, 1);
    run(8'd3,   8'd99,  8'd0,   8'd100, 8'd10,  3'd4, 1'b0, 12'h100, 11'd212,  2);
    run(8'd49,  8'd50,  8'd50,  8'd50,  8'd1,   3'd2, 1'b1, 12'h050, 11'd200,  0);

    C1 = 8'd20; C2 = 8'd21; C3 = 8'd22; C4 = 8'd23; Nulo = 8'd24;
    Finish = 1'b0;
    @(negedge Clock);
    Finish = 1'b1;
    repeat (8) @(negedge Clock);
    #2 Reset = 1'b1;
    #1;
    check("midconv_rst_busy", int'(Busy), 0);
    check("midconv_rst_done", int'(Done), 0);
    check("midconv_rst_winner", int'(Winner), 0);
    check("midconv_rst_bcd", int'(WinnerBCD), 0);
    check("midconv_rst_total", int'(Total), 0);
    @(negedge Clock);
    Reset = 1'b0;
    Finish = 1'b0;
    @(negedge Clock);

    run(8'd12, 8'd34, 8'd56, 8'd78, 8'd90, 3'd4, 1'b0, 12'h078, 11'd270, 0);

    repeat (5) @(negedge Clock);
    check("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
